// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the architectural PC, fetches from instruction memory
// with a req/ack handshake and hands each word to decode via valid/stall.
// Halts (sticky error) on a misaligned next PC or a fetch that is never acked.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    output logic [31:0] fetch_cnt,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [XLEN-1:0]   pc_nx;
    logic [XLEN-1:0]   instr_nx;
    logic [XLEN-1:0]   cnt_nx;
    logic              valid_nx;
    logic              req_nx;
    logic              mis_nx;
    logic              to_nx;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_nx;

    // The fetch address is always the PC of the instruction in flight.
    assign imem_addr = pc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and next-value logic; every register holds unless a branch below updates it.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instr;
        cnt_nx   = fetch_cnt;
        valid_nx = instr_valid;
        mis_nx   = misalign_err;
        to_nx    = timeout_err;
        wait_nx  = wait_q;

        unique case (state)
            S_IDLE: begin
                state_nx = S_FETCH;
            end

            S_FETCH: begin
                // An ack in the last allowed request cycle still completes the fetch.
                if (imem_ack) begin
                    instr_nx = imem_rdata;
                    valid_nx = 1'b1;
                    wait_nx  = '0;
                    state_nx = S_ISSUE;
                end else if (wait_q == WAIT_LAST) begin
                    to_nx    = 1'b1;
                    wait_nx  = '0;
                    state_nx = S_HALT;
                end else begin
                    wait_nx = wait_q + WAIT_W'(1);
                end
            end

            S_ISSUE: begin
                // PC takes npc even when misaligned so the faulting target is visible.
                if (!stall) begin
                    pc_nx    = npc;
                    cnt_nx   = fetch_cnt + XLEN'(1);
                    valid_nx = 1'b0;
                    if (npc[1:0] == 2'b00) begin
                        state_nx = S_FETCH;
                    end else begin
                        mis_nx   = 1'b1;
                        state_nx = S_HALT;
                    end
                end
            end

            S_HALT: begin
                valid_nx = 1'b0;
            end

            default: begin
                state_nx = S_HALT;
            end
        endcase

        req_nx = (state_nx == S_FETCH);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            instr        <= '0;
            instr_valid  <= 1'b0;
            fetch_cnt    <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            wait_q       <= '0;
            imem_req     <= 1'b0;
        end else begin
            pc           <= pc_nx;
            instr        <= instr_nx;
            instr_valid  <= valid_nx;
            fetch_cnt    <= cnt_nx;
            misalign_err <= mis_nx;
            timeout_err  <= to_nx;
            wait_q       <= wait_nx;
            imem_req     <= req_nx;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: plays instruction memory and decode around pc_fetch_ctrl,
// predicting every observable from the transaction sequence it drives.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned TMO    = 16;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic [31:0] fetch_cnt;
    logic        misalign_err;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    // Reference state: what the PC, count and presented word should be.
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] exp_instr;

    pc_fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .npc          (npc),
        .pc           (pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .fetch_cnt    (fetch_cnt),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pc"}, pc, RST_PC);
        chk({tag, ".req"}, 32'(imem_req), 32'd0);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".instr"}, instr, 32'd0);
        chk({tag, ".cnt"}, fetch_cnt, 32'd0);
        chk({tag, ".mis"}, 32'(misalign_err), 32'd0);
        chk({tag, ".tmo"}, 32'(timeout_err), 32'd0);
    endtask

    // Asynchronous reset pulse, deliberately off the clock edges.
    task automatic do_reset(input logic ack_during);
        @(negedge clk);
        #3 rst = 1'b1;
        imem_ack = ack_during;
        #1 chk_reset_vals("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc  = RST_PC;
        exp_cnt = 32'd0;
        chk("idle.req", 32'(imem_req), 32'd0);
    endtask

    // Memory side: answer the pending request after `delay` empty request cycles.
    task automatic do_fetch(input int delay);
        logic [31:0] word;
        word = $urandom();
        for (int i = 0; i < delay; i++) begin
            chk("fetch.req", 32'(imem_req), 32'd1);
            chk("fetch.addr", imem_addr, exp_pc);
            chk("fetch.valid", 32'(instr_valid), 32'd0);
            imem_ack   = 1'b0;
            imem_rdata = $urandom();
            step();
        end
        chk("fetch.req_ack", 32'(imem_req), 32'd1);
        chk("fetch.addr_ack", imem_addr, exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack  = 1'b0;
        exp_instr = word;
        chk("issue.valid", 32'(instr_valid), 32'd1);
        chk("issue.instr", instr, exp_instr);
        chk("issue.req", 32'(imem_req), 32'd0);
        chk("issue.pc", pc, exp_pc);
    endtask

    // Decode side: stall for `nstall` cycles (with stray acks), then take npc.
    task automatic do_issue(input int nstall, input logic [31:0] next);
        for (int i = 0; i < nstall; i++) begin
            stall      = 1'b1;
            npc        = $urandom();
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom();
            step();
            chk("stall.pc", pc, exp_pc);
            chk("stall.instr", instr, exp_instr);
            chk("stall.valid", 32'(instr_valid), 32'd1);
            chk("stall.cnt", fetch_cnt, exp_cnt);
            chk("stall.req", 32'(imem_req), 32'd0);
        end
        stall    = 1'b0;
        npc      = next;
        imem_ack = 1'($urandom_range(0, 1));
        step();
        imem_ack = 1'b0;
        npc      = $urandom();
        exp_pc   = next;
        exp_cnt  = exp_cnt + 32'd1;
        chk("hs.pc", pc, exp_pc);
        chk("hs.cnt", fetch_cnt, exp_cnt);
        chk("hs.valid", 32'(instr_valid), 32'd0);
        if (next[1:0] == 2'b00) begin
            chk("hs.req", 32'(imem_req), 32'd1);
            chk("hs.addr", imem_addr, next);
            chk("hs.mis", 32'(misalign_err), 32'd0);
        end else begin
            chk("hs.req_halt", 32'(imem_req), 32'd0);
            chk("hs.mis_set", 32'(misalign_err), 32'd1);
        end
    endtask

    // Halted: nothing may move, whatever memory does.
    task automatic chk_halted(input int cycles, input logic exp_mis, input logic exp_tmo);
        for (int i = 0; i < cycles; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom();
            npc        = $urandom();
            step();
            chk("halt.req", 32'(imem_req), 32'd0);
            chk("halt.valid", 32'(instr_valid), 32'd0);
            chk("halt.pc", pc, exp_pc);
            chk("halt.cnt", fetch_cnt, exp_cnt);
            chk("halt.mis", 32'(misalign_err), 32'(exp_mis));
            chk("halt.tmo", 32'(timeout_err), 32'(exp_tmo));
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        int          nreq;
        logic [31:0] target;

        rst        = 1'b1;
        npc        = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        stall      = 1'b0;
        exp_pc     = RST_PC;
        exp_cnt    = 32'd0;
        exp_instr  = 32'd0;

        #1 chk_reset_vals("rst_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("idle0.req", 32'(imem_req), 32'd0);
        step();

        // Sequential stream 0,4,8 with immediate acks and no stalls.
        for (int i = 0; i < 3; i++) begin
            do_fetch(0);
            do_issue(0, exp_pc + 32'd4);
        end
        chk("seq.cnt3", fetch_cnt, 32'd3);
        chk("seq.pc", pc, 32'd12);

        // Delayed ack, then a long stall with a jump to 0x40.
        do_fetch(5);
        do_issue(4, 32'h0000_0040);

        // Randomized stream of aligned targets, ack delays and stalls.
        for (int i = 0; i < 30; i++) begin
            target = $urandom() & 32'hFFFF_FFFC;
            do_fetch(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO - 1)) : 0);
            do_issue(int'($urandom_range(0, 3)), target);
        end

        // Ack on the last allowed request cycle still completes.
        do_fetch(TMO - 1);
        chk("late_ack.tmo", 32'(timeout_err), 32'd0);

        // Misaligned target halts with the bad PC visible.
        do_issue(1, 32'h0000_0042);
        chk("mis.pc", pc, 32'h0000_0042);
        chk_halted(4, 1'b1, 1'b0);

        // No ack at all: exactly TMO request cycles, then timeout halt.
        do_reset(1'b0);
        step();
        nreq = 0;
        while (imem_req === 1'b1 && nreq < 100) begin
            imem_ack = 1'b0;
            chk("tmo.addr", imem_addr, RST_PC);
            nreq++;
            step();
        end
        chk("tmo.nreq", 32'(nreq), 32'(TMO));
        chk("tmo.err", 32'(timeout_err), 32'd1);
        chk_halted(3, 1'b0, 1'b1);

        // Reset mid-wait with an ack pending across the idle cycle.
        do_reset(1'b0);
        step();
        do_fetch(0);
        do_issue(0, 32'h0000_0100);
        imem_ack = 1'b0;
        step();
        step();
        do_reset(1'b1);
        step();
        chk("post_rst.req", 32'(imem_req), 32'd1);
        chk("post_rst.valid", 32'(instr_valid), 32'd0);
        chk("post_rst.addr", imem_addr, RST_PC);
        imem_ack = 1'b0;
        do_fetch(2);
        do_issue(0, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
